// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end.
// Holds the default array geometry, the drain length helper and the
// feeder state encoding used by systolic_skew_feeder.
package systolic_pkg;

  localparam int unsigned ARR_SIZE      = 4;
  localparam int unsigned VERTICAL_BW   = 32;
  localparam int unsigned HORIZONTAL_BW = 16;
  localparam int unsigned DEPTH_W       = 16;

  // Cycles of zero injection needed after the last beat so that the most
  // delayed lane has pushed its final operand through the whole array.
  function automatic int unsigned drain_cycles(input int unsigned arr_size);
    return 2 * arr_size - 1;
  endfunction

  localparam int unsigned DRAIN_CYCLES = drain_cycles(ARR_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to skew one operand lane.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - lane word entering stage 0
//   q_o    - lane word leaving the last stage (latency DEPTH cycles)
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for the systolic MAC array.
// Accepts one wavefront of ARR_SIZE vertical and ARR_SIZE horizontal words
// per handshake, delays lane k by k+1 cycles (diagonal skew) and sequences a
// pass of K beats followed by a zero-flush drain and a one-cycle done pulse.
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-low reset
//   start            - begin a pass (sampled in IDLE only)
//   k_len            - beats in the pass, latched on start
//   mode_in          - array mode, latched on start
//   in_valid         - upstream beat valid
//   in_ready         - feeder accepts a beat (LOAD state)
//   in_vert/in_horz  - packed input lanes, lane k at [k*BW +: BW]
//   vertical_input   - skewed vertical lanes to the array
//   horizontal_input - skewed horizontal lanes to the array
//   i_mode           - latched mode to the array
//   busy             - high in LOAD and DRAIN
//   done             - one-cycle pass-complete pulse
module systolic_skew_feeder #(
  parameter int unsigned ARR_SIZE      = systolic_pkg::ARR_SIZE,
  parameter int unsigned VERTICAL_BW   = systolic_pkg::VERTICAL_BW,
  parameter int unsigned HORIZONTAL_BW = systolic_pkg::HORIZONTAL_BW,
  parameter int unsigned DEPTH_W       = systolic_pkg::DEPTH_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DEPTH_W-1:0]                k_len,
  input  logic                              mode_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [VERTICAL_BW*ARR_SIZE-1:0]   in_vert,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] in_horz,
  output logic [VERTICAL_BW*ARR_SIZE-1:0]   vertical_input,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
  output logic                              i_mode,
  output logic                              busy,
  output logic                              done
);

  import systolic_pkg::*;

  localparam int unsigned DRAIN_LEN = drain_cycles(ARR_SIZE);
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);

  feeder_state_e      state_q, state_d;
  logic [DEPTH_W-1:0] k_q, k_d;
  logic [DEPTH_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               accept;

  logic [VERTICAL_BW*ARR_SIZE-1:0]   inj_vert;
  logic [HORIZONTAL_BW*ARR_SIZE-1:0] inj_horz;

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign i_mode   = mode_q;
  assign accept   = in_valid & in_ready;

  // The array advances every cycle, so a missing beat becomes a zero slice
  // (accumulation-neutral) rather than a stall.
  assign inj_vert = accept ? in_vert : '0;
  assign inj_horz = accept ? in_horz : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mode_d      = mode_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            k_d        = k_len;
            mode_d     = mode_in;
            beat_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + DEPTH_W'(1);
          // Compare against K-1 so K = 2^DEPTH_W-1 finishes without wrapping.
          if (beat_cnt_q == k_q - DEPTH_W'(1)) begin
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_LEN - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
    skew_delay_line #(
      .WIDTH (VERTICAL_BW),
      .DEPTH (k + 1)
    ) u_vert_skew (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (inj_vert[k*VERTICAL_BW +: VERTICAL_BW]),
      .q_o    (vertical_input[k*VERTICAL_BW +: VERTICAL_BW])
    );

    skew_delay_line #(
      .WIDTH (HORIZONTAL_BW),
      .DEPTH (k + 1)
    ) u_horz_skew (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (inj_horz[k*HORIZONTAL_BW +: HORIZONTAL_BW]),
      .q_o    (horizontal_input[k*HORIZONTAL_BW +: HORIZONTAL_BW])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (ARR_SIZE=4).
// Beat id n>0 drives horz lane k = (n-1)*16 + k+1 and vert lane k =
// (n-1)*256 + 10*(k+1); id 0 means all-zero lanes.
module tb_systolic_skew_feeder;

  localparam int unsigned N  = 4;
  localparam int unsigned VB = 32;
  localparam int unsigned HB = 16;
  localparam int unsigned DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DW-1:0]     k_len;
  logic              mode_in;
  logic              in_valid;
  logic              in_ready;
  logic [VB*N-1:0]   in_vert;
  logic [HB*N-1:0]   in_horz;
  logic [VB*N-1:0]   vertical_input;
  logic [HB*N-1:0]   horizontal_input;
  logic              i_mode;
  logic              busy;
  logic              done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .ARR_SIZE      (N),
    .VERTICAL_BW   (VB),
    .HORIZONTAL_BW (HB),
    .DEPTH_W       (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .k_len            (k_len),
    .mode_in          (mode_in),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_vert          (in_vert),
    .in_horz          (in_horz),
    .vertical_input   (vertical_input),
    .horizontal_input (horizontal_input),
    .i_mode           (i_mode),
    .busy             (busy),
    .done             (done)
  );

  typedef struct {
    logic        start;
    logic [15:0] klen;
    logic        mode;
    logic        valid;
    logic [2:0]  in_id;
    logic        busy;
    logic        ready;
    logic        done;
    logic        imode;
    logic [11:0] out_ids;   // lane k expected beat id at [3k +: 3]
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic s, input logic [15:0] kl, input logic m,
                              input logic v, input logic [2:0] id,
                              input logic b, input logic r, input logic d, input logic im,
                              input logic [2:0] o0, input logic [2:0] o1,
                              input logic [2:0] o2, input logic [2:0] o3);
    vec_t t;
    t.start = s; t.klen = kl; t.mode = m; t.valid = v; t.in_id = id;
    t.busy = b; t.ready = r; t.done = d; t.imode = im;
    t.out_ids = {o3, o2, o1, o0};
    return t;
  endfunction

  function automatic logic [HB-1:0] hpat(input logic [2:0] id, input int k);
    if (id == 3'd0) return '0;
    return HB'((int'(id) - 1) * 16 + k + 1);
  endfunction

  function automatic logic [VB-1:0] vpat(input logic [2:0] id, input int k);
    if (id == 3'd0) return '0;
    return VB'((int'(id) - 1) * 256 + 10 * (k + 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] kl, input logic m,
                       input logic v, input logic [2:0] id);
    start    = s;
    k_len    = kl;
    mode_in  = m;
    in_valid = v;
    for (int k = 0; k < int'(N); k++) begin
      in_horz[k*HB +: HB] = hpat(id, k);
      in_vert[k*VB +: VB] = vpat(id, k);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [11:0] ids);
    for (int k = 0; k < int'(N); k++) begin
      chk($sformatf("%s horz%0d", tag, k), 32'(horizontal_input[k*HB +: HB]),
          32'(hpat(ids[3*k +: 3], k)));
      chk($sformatf("%s vert%0d", tag, k), vertical_input[k*VB +: VB],
          vpat(ids[3*k +: 3], k));
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic b, input logic r,
                          input logic d, input logic im);
    chk({tag, " busy"},     32'(busy),     32'(b));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(r));
    chk({tag, " done"},     32'(done),     32'(d));
    chk({tag, " i_mode"},   32'(i_mode),   32'(im));
  endtask

  initial begin
    int unsigned n;
    int unsigned guard;

    // K=1 pass (c0..c10), then K=3 with one bubble (c11..c24)
    tbl[0]  = mk(1, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1,  1, 1, 0, 1,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1,  1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 2,  1, 0, 0, 1,  0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1,  0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1,  0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1,  0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1,  0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1,  0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 1,  0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0);
    tbl[11] = mk(1, 3, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, 2,  1, 1, 0, 0,  0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 1, 3,  1, 1, 0, 0,  2, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 5,  1, 1, 0, 0,  3, 2, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 4,  1, 1, 0, 0,  0, 3, 2, 0);
    tbl[16] = mk(0, 0, 0, 1, 6,  1, 0, 0, 0,  4, 0, 3, 2);
    tbl[17] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 4, 0, 3);
    tbl[18] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 4, 0);
    tbl[19] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 4);
    tbl[20] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_ctrl("reset", 0, 0, 0, 0);
    chk_lanes("reset", '0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      chk_ctrl($sformatf("vec%0d", i), tbl[i].busy, tbl[i].ready, tbl[i].done, tbl[i].imode);
      chk_lanes($sformatf("vec%0d", i), tbl[i].out_ids);
      drive(tbl[i].start, tbl[i].klen, tbl[i].mode, tbl[i].valid, tbl[i].in_id);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();

    // k_len = 0: done next cycle, never busy
    drive(1, 0, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk_ctrl("k0 pulse", 0, 0, 1, 0);
    chk_lanes("k0 pulse", '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ctrl($sformatf("k0 after%0d", i), 0, 0, 0, 0);
      chk_lanes($sformatf("k0 after%0d", i), '0);
    end

    // mode and start isolation during LOAD, K=4
    drive(1, 4, 1, 0, 0);
    step();
    chk_ctrl("iso load", 1, 1, 0, 1);
    for (int b = 0; b < 4; b++) begin
      drive(b == 1, 9, (b % 2) == 1 ? 1'b1 : 1'b0, 1, 3'(b + 1));
      step();
      chk($sformatf("iso b%0d i_mode", b), 32'(i_mode), 32'd1);
    end
    drive(0, 0, 0, 0, 0);
    chk("iso drain ready", 32'(in_ready), 32'd0);
    chk("iso drain busy", 32'(busy), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("iso done c%0d", c), 32'(done), 32'(c == 7));
      chk($sformatf("iso mode c%0d", c), 32'(i_mode), 32'd1);
    end
    step();

    // asynchronous reset mid-pass after 2 of 4 beats
    drive(1, 4, 1, 0, 0);
    step();
    drive(0, 0, 1, 1, 1);
    step();
    drive(0, 0, 1, 1, 2);
    step();
    chk("rst pre lane0", 32'(horizontal_input[HB-1:0]), 32'(hpat(2, 0)));
    drive(0, 0, 1, 1, 3);
    #3;
    rst = 1'b0;
    #1;
    chk_ctrl("rst async", 0, 0, 0, 0);
    chk_lanes("rst async", '0);
    step();
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk_ctrl($sformatf("rst post%0d", i), 0, 0, 0, 0);
    end

    // back-to-back: start while done is high
    drive(1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("b2b first done wait", guard, 7);
    drive(1, 2, 1, 0, 0);
    step();
    chk_ctrl("b2b load", 1, 1, 0, 1);
    drive(0, 0, 0, 1, 2);
    step();
    chk("b2b still load", 32'(in_ready), 32'd1);
    drive(0, 0, 0, 1, 3);
    step();
    drive(0, 0, 0, 0, 0);
    chk("b2b drain ready", 32'(in_ready), 32'd0);
    chk("b2b lane0", 32'(horizontal_input[HB-1:0]), 32'(hpat(3, 0)));
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("b2b done c%0d", c), 32'(done), 32'(c == 7));
    end
    step();

    // maximum pass length must not wrap the beat counter
    drive(1, 16'hFFFF, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 1);
    n = 0;
    guard = 0;
    while (guard < 70000) begin
      if (in_ready !== 1'b1) break;
      n++;
      step();
      guard++;
    end
    drive(0, 0, 0, 0, 0);
    chk("maxK beats", n, 32'd65535);
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("maxK done c%0d", c), 32'(done), 32'(c == 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
